seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
- Parametrised serial pattern-detector FSM. Successor to the fixed 2-state Moore detector.
- Detects a runtime-loadable PAT_W-bit pattern in a qualified serial bit stream.
- Supports overlapping and non-overlapping modes, a registered one-cycle match pulse and a saturating match counter.
- Sits on serial control/monitor paths feeding status and interrupt logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- PAT_RESET, 4'b1011 (width PAT_W), pattern loaded at reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_bit; a bit is accepted only when high.
- in_bit  input  1  serial data bit.
- pat_load  input  1  load pat_value into the pattern register.
- pat_value  input  PAT_W  new pattern; bit PAT_W-1 is the first bit expected on the stream.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- match  output  1  registered one-cycle pulse on pattern completion.
- match_count  output  CNT_W  saturating count of matches.
- prefix_len  output  clog2(PAT_W)  current FSM state (matched-prefix length), debug.

Behaviour:
- Reset values: state 0, match 0, match_count 0, pattern = PAT_RESET.
- Reset taken mid-pattern discards any partial match.
- State encoding: FSM state k in 0..PAT_W-1 equals the length of the longest pattern prefix that is a suffix of the accepted bits since the last restart.
- Cycle with in_valid=0 and pat_load=0:
  - State, pattern and counter hold.
  - match deasserts.
  - Gaps in in_valid never break a partial match.
- Accepted bit b while in state k:
  - If b equals pattern bit (PAT_W-1-k) and k+1 < PAT_W: next state k+1.
  - If b equals that bit and k+1 == PAT_W (completion):
    - match=1 on the following cycle.
    - match_count increments.
    - Next state = longest proper border of the pattern if overlap_en=1, else 0.
  - On mismatch: next state = longest j < k+1 such that the last j accepted bits equal the first j pattern bits (KMP fallback). May be 0.
  - The fallback is computed combinationally, within the same cycle.
- Latency: match is high for exactly the one clock cycle after the posedge that accepts the final pattern bit. Back-to-back completions give back-to-back pulses.
- overlap_en is sampled only on the completing bit; changing it at any other time has no effect.
- pat_load=1:
  - Pattern register takes pat_value.
  - State goes to 0 and match goes to 0.
  - match_count is unchanged.
  - pat_load takes priority over a simultaneous in_valid; that bit is discarded.
- match_count saturates at all-ones; further matches still pulse match.
- The match pulse is independent of counter saturation.

Optional Feature:
- Macro: SEQDET_COUNT_CLR_EN.
- Defined: adds port count_clr (input, 1 bit).
  - count_clr=1 zeroes match_count on the next edge.
  - If a match completes in the same cycle, the result is 0; clear wins.
- Undefined: no count_clr port; match_count clears only on reset.

Test Plan:
- Pattern 1011, overlap_en=1, stream 1,0,1,1,0,1,1 (in_valid=1 every cycle) -> match pulses after bit 4 and after bit 7; match_count=2; prefix_len=1 at the end.
- Same pattern and stream with overlap_en=0 -> single match after bit 4; match_count=1; final prefix_len=1.
- pat_load with pattern 1111, overlap_en=1, six consecutive 1s -> match after bits 4, 5 and 6 (3 consecutive cycles); match_count=3. With overlap_en=0 -> 1 match; final prefix_len=2.
- Pattern 1011, stream 1,0,1 then in_valid=0 for 5 cycles, then 1 -> prefix_len holds at 3 during the gap; match asserts one cycle after the final 1.
- reset asserted after 1,0,1, then stream 1 -> no match; prefix_len=1; match_count=0. Also: pat_load together with in_valid=1 -> bit ignored, prefix_len=0.
- CNT_W=2, pattern 1111 overlapping, eight 1s -> 5 match pulses; match_count saturates at 3. With SEQDET_COUNT_CLR_EN, count_clr pulse -> match_count=0 next cycle.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: a KMP-style FSM that finds a runtime-loadable PAT_W-bit pattern.
// Define SEQDET_COUNT_CLR_EN to add the count_clr port, a synchronous clear for match_count.
module seq_pattern_detector #(
  parameter int                 PAT_W     = 4,
  parameter logic [PAT_W-1:0]   PAT_RESET = 4'b1011,
  parameter int                 CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_bit,
  input  logic                      pat_load,
  input  logic [PAT_W-1:0]          pat_value,
  input  logic                      overlap_en,
`ifdef SEQDET_COUNT_CLR_EN
  input  logic                      count_clr,
`endif
  output logic                      match,
  output logic [CNT_W-1:0]          match_count,
  output logic [$clog2(PAT_W)-1:0]  prefix_len
);

  localparam int ST_W = $clog2(PAT_W);
  localparam logic [PAT_W:0] ONE = (PAT_W+1)'(1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PAT_W-1:0] pat_rev;
  logic             exp_bit, hit, last, complete;
  logic [ST_W-1:0]  fb_state;

  // Longest j <= k such that the last j bits of (prefix_k, b) equal the first j pattern bits.
  // With k = PAT_W-1 and b equal to the final pattern bit this is the pattern's longest proper border.
  function automatic logic [ST_W-1:0] kmp_next(input logic [ST_W-1:0] k, input logic b,
                                              input logic [PAT_W-1:0] pat);
    logic [PAT_W:0]  seen;
    logic [PAT_W:0]  pre;
    logic [PAT_W:0]  mask;
    logic [ST_W-1:0] best;
    best = '0;
    seen = {pat >> (PAT_W - int'(k)), b};
    for (int j = 1; j < PAT_W; j++) begin
      pre  = {1'b0, pat >> (PAT_W - j)};
      mask = (ONE << j) - ONE;
      if (j <= int'(k) && ((seen ^ pre) & mask) == '0) begin
        best = ST_W'(j);
      end
    end
    return best;
  endfunction

  // pat_rev[k] is the k-th bit expected on the stream.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_rev
      assign pat_rev[gi] = pat_q[PAT_W-1-gi];
    end
  endgenerate

  assign exp_bit  = pat_rev[state_q];
  assign hit      = (in_bit == exp_bit);
  assign last     = (state_q == ST_W'(PAT_W-1));
  assign fb_state = kmp_next(state_q, in_bit, pat_q);
  assign complete = !pat_load && in_valid && hit && last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      pat_q   <= PAT_RESET;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    if (pat_load) begin
      pat_d   = pat_value;
      state_d = '0;
    end else if (in_valid) begin
      if (hit && !last) begin
        state_d = state_q + 1'b1;
      end else if (hit && last) begin
        state_d = overlap_en ? fb_state : '0;
      end else begin
        state_d = fb_state;
      end
    end
  end

  always_comb begin
    match_d = complete;
    count_d = count_q;
    if (complete && count_q != '1) begin
      count_d = count_q + 1'b1;
    end
`ifdef SEQDET_COUNT_CLR_EN
    if (count_clr) begin
      count_d = '0;
    end
`endif
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign prefix_len  = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: a history-based reference model feeds an expected queue.
module tb_seq_pattern_detector;
  localparam int PAT_W = 4;
  localparam logic [3:0] PAT_RST = 4'b1011;
  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_bit, pat_load, overlap_en, count_clr;
  logic [3:0] pat_value;
  logic       match_a, match_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] pl_a, pl_b;

  typedef struct {
    int    m;
    int    cnt_a;
    int    cnt_b;
    int    pl;
    string tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  bit         hist[$];
  logic [3:0] m_pat;
  int         m_cnt_a, m_cnt_b;
  int         tests = 0;
  int         failed = 0;
  int         txn = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(4), .PAT_RESET(PAT_RST), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_value(pat_value), .overlap_en(overlap_en),
`ifdef SEQDET_COUNT_CLR_EN
    .count_clr(count_clr),
`endif
    .match(match_a), .match_count(cnt_a), .prefix_len(pl_a)
  );

  seq_pattern_detector #(.PAT_W(4), .PAT_RESET(PAT_RST), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_value(pat_value), .overlap_en(overlap_en),
`ifdef SEQDET_COUNT_CLR_EN
    .count_clr(count_clr),
`endif
    .match(match_b), .match_count(cnt_b), .prefix_len(pl_b)
  );

  // Model: keep the bits accepted since the last restart; a match is the pattern as a suffix,
  // and the state is the longest proper pattern prefix that is a suffix of that history.
  task automatic step(input logic rst, input logic v, input logic b, input logic ld,
                      input logic [3:0] pv, input logic ov, input logic clr, input string tag);
    exp_t e;
    int   best;
    bit   ok;
    bit   hitm;
`ifndef SEQDET_COUNT_CLR_EN
    clr = 1'b0;
`endif
    reset = rst; in_valid = v; in_bit = b; pat_load = ld;
    pat_value = pv; overlap_en = ov; count_clr = clr;
    hitm = 1'b0;
    if (rst) begin
      hist.delete();
      m_pat = PAT_RST;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      if (ld) begin
        m_pat = pv;
        hist.delete();
      end else if (v) begin
        hist.push_back(b);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        if (hist.size() == PAT_W) begin
          hitm = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (hist[i] != m_pat[PAT_W-1-i]) hitm = 1'b0;
        end
        if (hitm) begin
          if (m_cnt_a < MAX_A) m_cnt_a++;
          if (m_cnt_b < MAX_B) m_cnt_b++;
          if (!ov) hist.delete();
        end
      end
      if (count_clr) begin
        m_cnt_a = 0;
        m_cnt_b = 0;
      end
    end
    best = 0;
    for (int j = 1; j < PAT_W; j++) begin
      if (hist.size() >= j) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++)
          if (hist[hist.size()-j+i] != m_pat[PAT_W-1-i]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    e.m = int'(hitm); e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b; e.pl = best; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic ov, input string tag);
    step(1'b0, 1'b1, b, 1'b0, 4'b0000, ov, 1'b0, tag);
  endtask

  task automatic gap(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [3:0] pv, input logic v, input logic b, input string tag);
    step(1'b0, v, b, 1'b1, pv, 1'b0, 1'b0, tag);
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s txn %0d: got %0d expected %0d", name, txn, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      txn++;
      check({mon_e.tag, ".match_a"}, int'(match_a), mon_e.m);
      check({mon_e.tag, ".match_b"}, int'(match_b), mon_e.m);
      check({mon_e.tag, ".count_a"}, int'(cnt_a), mon_e.cnt_a);
      check({mon_e.tag, ".count_b"}, int'(cnt_b), mon_e.cnt_b);
      check({mon_e.tag, ".prefix_a"}, int'(pl_a), mon_e.pl);
      check({mon_e.tag, ".prefix_b"}, int'(pl_b), mon_e.pl);
      $display("[TB] txn %0d %s: match=%0d count=%0d/%0d prefix=%0d", txn, mon_e.tag,
               match_a, cnt_a, cnt_b, pl_a);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] bits3 [3];
    int r;
    bits3[0] = 2'd1; bits3[1] = 2'd0; bits3[2] = 2'd1;

    do_reset("reset");
    do_reset("reset");

    // 1011 overlapping, then non-overlapping, on 1,0,1,1,0,1,1
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 7; i++) begin
        bit_in((i == 1 || i == 4) ? 1'b0 : 1'b1, pass == 0, pass == 0 ? "ovl1011" : "non1011");
      end
      do_reset("reset");
    end

    // 1111 with six 1s, overlapping then not
    for (int pass = 0; pass < 2; pass++) begin
      load(4'b1111, 1'b0, 1'b0, "load1111");
      for (int i = 0; i < 6; i++) bit_in(1'b1, pass == 0, pass == 0 ? "ovl1111" : "non1111");
    end

    // gap in in_valid keeps the partial match
    do_reset("reset");
    for (int i = 0; i < 3; i++) bit_in(bits3[i][0], 1'b1, "pregap");
    for (int i = 0; i < 5; i++) gap("gap");
    bit_in(1'b1, 1'b1, "postgap");
    gap("gap");

    // reset mid-pattern, then pat_load colliding with a valid bit
    for (int i = 0; i < 3; i++) bit_in(bits3[i][0], 1'b1, "premid");
    do_reset("midrst");
    bit_in(1'b1, 1'b1, "postrst");
    load(4'b1011, 1'b1, 1'b1, "loadcoll");
    gap("gap");

    // saturation of the narrow counter: eight 1s on 1111 overlapping
    do_reset("reset");
    load(4'b1111, 1'b0, 1'b0, "load1111");
    for (int i = 0; i < 8; i++) bit_in(1'b1, 1'b1, "sat");
    gap("gap");

`ifdef SEQDET_COUNT_CLR_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, "clr");
    for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b1, "reclr");
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, "clrmatch");
    gap("gap");
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      step(r < 2, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), r >= 2 && r < 8,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0, "rand");
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
